// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared types and constants for the conv layer scheduler
package conv_sched_pkg;

    localparam int MAX_K      = 3;
    localparam int KW         = MAX_K * MAX_K;
    localparam int DESC_W     = 48;

    localparam int CH_LSB     = 0;
    localparam int K_LSB      = 8;
    localparam int STRIDE_LSB = 16;
    localparam int IF_LSB     = 24;
    localparam int FILT_LSB   = 32;
    localparam int LAST_BIT   = 40;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DESC_RD,
        S_DESC_WAIT,
        S_DESC_CALC,
        S_LOAD,
        S_DRAIN,
        S_START,
        S_READY,
        S_WAIT_REQ,
        S_LAYER_END,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic       last_stage;
        logic [7:0] amount_filters;
        logic [7:0] if_size;
        logic [7:0] stride;
        logic [7:0] kernel_size;
        logic [7:0] amount_channels;
    } desc_t;

    // Reserved descriptor bits above LAST_BIT are dropped by the caller.
    function automatic desc_t unpack_desc(input logic [LAST_BIT:0] raw);
        desc_t d;
        d.amount_channels = raw[CH_LSB +: 8];
        d.kernel_size     = raw[K_LSB +: 8];
        d.stride          = raw[STRIDE_LSB +: 8];
        d.if_size         = raw[IF_LSB +: 8];
        d.amount_filters  = raw[FILT_LSB +: 8];
        d.last_stage      = raw[LAST_BIT];
        return d;
    endfunction

endpackage

// File: rtl/conv_layer_scheduler_kernel_loader.sv
// rtl/conv_layer_scheduler_kernel_loader.sv - weight stream reader filling kernel and bias registers
module kernel_loader
    import conv_sched_pkg::*;
#(
    parameter int W_ADDR_BITS = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   restart_i,
    input  logic                   load_i,
    input  logic                   with_bias_i,
    input  logic [7:0]             count_i,
    output logic                   ack_o,
    output logic                   wgt_rd_o,
    output logic [W_ADDR_BITS-1:0] wgt_addr_o,
    input  logic [7:0]             wgt_data_i,
    output logic [7:0]             kernel_o [0:KW-1],
    output logic [7:0]             bias_o
);

    logic                   active_q;
    logic                   rd_q;
    logic                   take_bias_q;
    logic [7:0]             cnt_q;
    logic [7:0]             count_q;
    logic [3:0]             widx_q;
    logic [W_ADDR_BITS-1:0] ptr_q;
    logic [7:0]             kernel_q [0:KW-1];
    logic [7:0]             bias_q;

    assign ack_o      = active_q && (cnt_q == count_q - 8'd1);
    assign wgt_rd_o   = active_q;
    assign wgt_addr_o = ptr_q;
    assign kernel_o   = kernel_q;
    assign bias_o     = bias_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q    <= 1'b0;
            rd_q        <= 1'b0;
            take_bias_q <= 1'b0;
            cnt_q       <= '0;
            count_q     <= '0;
            widx_q      <= '0;
            ptr_q       <= '0;
            bias_q      <= '0;
            for (int i = 0; i < KW; i++) kernel_q[i] <= '0;
        end else begin
            if (restart_i) ptr_q <= '0;
            rd_q <= active_q;
            if (load_i) begin
                active_q    <= 1'b1;
                cnt_q       <= '0;
                count_q     <= count_i;
                take_bias_q <= with_bias_i;
                widx_q      <= '0;
                for (int i = 0; i < KW; i++) kernel_q[i] <= '0;
            end else begin
                if (active_q) begin
                    ptr_q <= ptr_q + 1'b1;
                    cnt_q <= cnt_q + 8'd1;
                    if (ack_o) active_q <= 1'b0;
                end
                // Data returns one cycle after each read; the bias byte leads a filter load.
                if (rd_q) begin
                    if (take_bias_q) begin
                        bias_q      <= wgt_data_i;
                        take_bias_q <= 1'b0;
                    end else if (widx_q < 4'(KW)) begin
                        kernel_q[widx_q] <= wgt_data_i;
                        widx_q           <= widx_q + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - multi-layer descriptor sequencer driving fsm_rn configuration and weights
module conv_layer_scheduler
    import conv_sched_pkg::*;
#(
    parameter int          DESC_ADDR_BITS = 4,
    parameter int          W_ADDR_BITS    = 14,
    parameter logic [15:0] BANK_OFFSET    = 16'd2048
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sched_start,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DESC_ADDR_BITS-1:0] layer_idx,
    output logic                      desc_rd,
    output logic [DESC_ADDR_BITS-1:0] desc_addr,
    input  logic [DESC_W-1:0]         desc_data,
    output logic                      wgt_rd,
    output logic [W_ADDR_BITS-1:0]    wgt_addr,
    input  logic [7:0]                wgt_data,
    output logic                      start,
    output logic                      struct_ready,
    output logic [7:0]                last_stage,
    output logic [7:0]                amount_channels,
    output logic [7:0]                kernel_size,
    output logic [7:0]                stride,
    output logic [7:0]                if_size,
    output logic [7:0]                kernel_size_2,
    output logic [7:0]                amount_filters,
    output logic [7:0]                of_size,
    output logic [15:0]               ifsize_2,
    output logic [15:0]               ofsize_2,
    output logic [15:0]               of_offset,
    output logic [15:0]               if_base,
    output logic [7:0]                kernel [0:KW-1],
    output logic [7:0]                bias,
    input  logic                      next,
    input  logic                      next_channel,
    input  logic                      next_filter
);

    state_t                    state_q, state_d;
    desc_t                     desc_q, desc_d;
    logic [DESC_ADDR_BITS-1:0] layer_idx_q, layer_idx_d;
    logic                      err_q, err_d;
    logic [7:0]                ch_q, ch_d;
    logic [7:0]                f_q, f_d;
    logic                      new_layer_q, new_layer_d;

    logic [7:0]  amount_channels_q, kernel_size_q, stride_q, if_size_q;
    logic [7:0]  amount_filters_q, last_stage_q, kernel_size_2_q, of_size_q;
    logic [15:0] ifsize_2_q, ofsize_2_q, of_offset_q, if_base_q;

    logic        unused_desc_bits;
    logic [7:0]  kk_calc, of_calc, ld_count;
    logic [15:0] if2_calc, of2_calc;
    logic        desc_invalid;
    logic        ld_go, ld_bias, ld_ack, run_start;

    assign unused_desc_bits = ^desc_data[DESC_W-1:LAST_BIT+1];

    assign kk_calc  = desc_q.kernel_size * desc_q.kernel_size;
    assign if2_calc = 16'(desc_q.if_size) * 16'(desc_q.if_size);
    assign of_calc  = ((desc_q.if_size - desc_q.kernel_size) >> desc_q.stride) + 8'd1;
    assign of2_calc = 16'(of_calc) * 16'(of_calc);

    assign desc_invalid = (desc_q.kernel_size == 8'd0) || (desc_q.kernel_size > 8'(MAX_K)) ||
                          (desc_q.if_size < desc_q.kernel_size) ||
                          (desc_q.amount_channels == 8'd0) || (desc_q.amount_filters == 8'd0);

    // The first load of a layer happens before kernel_size_2_q is registered.
    assign ld_count = ((state_q == S_DESC_CALC) ? kk_calc : kernel_size_2_q) + {7'd0, ld_bias};

    always_comb begin
        state_d     = state_q;
        desc_d      = desc_q;
        layer_idx_d = layer_idx_q;
        err_d       = err_q;
        ch_d        = ch_q;
        f_d         = f_q;
        new_layer_d = new_layer_q;
        ld_go       = 1'b0;
        ld_bias     = 1'b0;
        run_start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sched_start) begin
                    err_d       = 1'b0;
                    layer_idx_d = '0;
                    run_start   = 1'b1;
                    state_d     = S_DESC_RD;
                end
            end
            S_DESC_RD:   state_d = S_DESC_WAIT;
            S_DESC_WAIT: begin
                desc_d  = unpack_desc(desc_data[LAST_BIT:0]);
                state_d = S_DESC_CALC;
            end
            S_DESC_CALC: begin
                if (desc_invalid) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    ch_d        = '0;
                    f_d         = '0;
                    new_layer_d = 1'b1;
                    ld_go       = 1'b1;
                    ld_bias     = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD:  if (ld_ack) state_d = S_DRAIN;
            S_DRAIN: state_d = new_layer_q ? S_START : S_READY;
            S_START: begin
                new_layer_d = 1'b0;
                state_d     = S_READY;
            end
            S_READY: state_d = S_WAIT_REQ;
            S_WAIT_REQ: begin
                if (next) begin
                    if (next_filter) begin
                        if (ch_q != amount_channels_q - 8'd1) begin
                            err_d   = 1'b1;
                            state_d = S_FINISH;
                        end else if (f_q != amount_filters_q - 8'd1) begin
                            f_d     = f_q + 8'd1;
                            ch_d    = '0;
                            ld_go   = 1'b1;
                            ld_bias = 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_LAYER_END;
                        end
                    end else if (ch_q != amount_channels_q - 8'd1) begin
                        ch_d    = ch_q + 8'd1;
                        ld_go   = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_LAYER_END: begin
                if (last_stage_q[0]) begin
                    state_d = S_FINISH;
                end else if (layer_idx_q == '1) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    layer_idx_d = layer_idx_q + 1'b1;
                    state_d     = S_DESC_RD;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (next && (state_q != S_WAIT_REQ)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            desc_q      <= '0;
            layer_idx_q <= '0;
            err_q       <= 1'b0;
            ch_q        <= '0;
            f_q         <= '0;
            new_layer_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            desc_q      <= desc_d;
            layer_idx_q <= layer_idx_d;
            err_q       <= err_d;
            ch_q        <= ch_d;
            f_q         <= f_d;
            new_layer_q <= new_layer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            amount_channels_q <= '0;
            kernel_size_q     <= '0;
            stride_q          <= '0;
            if_size_q         <= '0;
            amount_filters_q  <= '0;
            last_stage_q      <= '0;
            kernel_size_2_q   <= '0;
            of_size_q         <= '0;
            ifsize_2_q        <= '0;
            ofsize_2_q        <= '0;
            of_offset_q       <= '0;
            if_base_q         <= '0;
        end else if (state_q == S_DESC_CALC) begin
            amount_channels_q <= desc_q.amount_channels;
            kernel_size_q     <= desc_q.kernel_size;
            stride_q          <= desc_q.stride;
            if_size_q         <= desc_q.if_size;
            amount_filters_q  <= desc_q.amount_filters;
            last_stage_q      <= {7'd0, desc_q.last_stage};
            kernel_size_2_q   <= kk_calc;
            of_size_q         <= of_calc;
            ifsize_2_q        <= if2_calc;
            ofsize_2_q        <= of2_calc;
            // Even layers read bank A and write bank B; odd layers swap.
            of_offset_q       <= layer_idx_q[0] ? 16'd0 : BANK_OFFSET;
            if_base_q         <= layer_idx_q[0] ? BANK_OFFSET : 16'd0;
        end
    end

    kernel_loader #(
        .W_ADDR_BITS(W_ADDR_BITS)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .restart_i  (run_start),
        .load_i     (ld_go),
        .with_bias_i(ld_bias),
        .count_i    (ld_count),
        .ack_o      (ld_ack),
        .wgt_rd_o   (wgt_rd),
        .wgt_addr_o (wgt_addr),
        .wgt_data_i (wgt_data),
        .kernel_o   (kernel),
        .bias_o     (bias)
    );

    assign busy            = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done            = (state_q == S_FINISH);
    assign err             = err_q;
    assign layer_idx       = layer_idx_q;
    assign desc_rd         = (state_q == S_DESC_RD);
    assign desc_addr       = layer_idx_q;
    assign start           = (state_q == S_START);
    assign struct_ready    = (state_q == S_READY);
    assign last_stage      = last_stage_q;
    assign amount_channels = amount_channels_q;
    assign kernel_size     = kernel_size_q;
    assign stride          = stride_q;
    assign if_size         = if_size_q;
    assign kernel_size_2   = kernel_size_2_q;
    assign amount_filters  = amount_filters_q;
    assign of_size         = of_size_q;
    assign ifsize_2        = ifsize_2_q;
    assign ofsize_2        = ofsize_2_q;
    assign of_offset       = of_offset_q;
    assign if_base         = if_base_q;

endmodule
